// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures each completed UART frame on the falling edge
// of rx_busy and lets a consumer pop bytes with one cycle of read latency.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              baud_clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_busy,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wptr_r;
  logic [ADDR_W-1:0] rptr_r;
  logic              busy_r;
  logic              armed_r;

  logic              push_req_s;
  logic              pop_ok_s;
  logic              push_ok_s;
  logic              ovf_evt_s;
  logic [ADDR_W:0]   count_next_s;

  // Frame completion, push/pop qualification and next occupancy.
  always_comb begin
    push_req_s   = armed_r & busy_r & ~rx_busy;
    pop_ok_s     = rd_en & ~empty;
    push_ok_s    = push_req_s & (~full | pop_ok_s);
    ovf_evt_s    = push_req_s & full & ~pop_ok_s;
    count_next_s = count;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count + CNT_ONE;
      2'b01:   count_next_s = count - CNT_ONE;
      default: count_next_s = count;
    endcase
  end

  // Edge detector and arming; arming waits for an idle line so a frame
  // already in flight at reset release is never pushed.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      busy_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      busy_r  <= rx_busy;
      armed_r <= armed_r | ~rx_busy;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge baud_clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= rx_data;
    end
  end

  // Pointers, occupancy and derived flags.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      wptr_r <= PTR_ZERO;
      rptr_r <= PTR_ZERO;
      count  <= CNT_ZERO;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      count <= count_next_s;
      // Flags follow next count so they stay aligned with the registered count.
      empty <= (count_next_s == CNT_ZERO);
      full  <= (count_next_s == CNT_FULL);
    end
  end

  // Read port: one-cycle latency, data holds between pops.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_ok_s;
      if (pop_ok_s) begin
        rd_data <= mem_r[rptr_r];
      end
    end
  end

  // Sticky overflow; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_evt_s) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: scenario tasks with a byte scoreboard.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              baud_clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_busy;
  logic              rd_en;
  logic              ovf_clr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int                checks   = 0;
  int                failures = 0;
  logic [7:0]        exp_q [$];
  logic [7:0]        exp_b;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .baud_clk (baud_clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_busy  (rx_busy),
    .rd_en    (rd_en),
    .ovf_clr  (ovf_clr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  // One receiver frame: 10 busy cycles, then the falling cycle carries the byte.
  task automatic send_frame(input logic [7:0] b, input bit keep, input bit clr);
    rx_busy = 1'b1;
    repeat (10) tick();
    rx_busy = 1'b0;
    rx_data = b;
    ovf_clr = clr;
    tick();
    ovf_clr = 1'b0;
    if (keep) exp_q.push_back(b);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_busy = 1'b0; rx_data = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;
    repeat (2) tick();
    checks++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
        count !== 5'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rd_data=%h rd_valid=%b empty=%b full=%b count=%0d overflow=%b, required 00 0 1 0 0 0",
               rd_data, rd_valid, empty, full, count, overflow);
    end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    tick();
    checks++;
    if (count !== 5'd3 || empty !== 1'b0) begin
      failures++;
      $display("FAIL basic_fill: count=%0d empty=%b, required 3 0", count, empty);
    end
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp_b = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
        failures++;
        $display("FAIL basic_read%0d: rd_valid=%b rd_data=%h, required 1 %h", i, rd_valid, rd_data, exp_b);
      end
      tick();
    end
    checks++;
    if (empty !== 1'b1 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_empty: empty=%b rd_valid=%b, required 1 0", empty, rd_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_fill: full=%b count=%0d overflow=%b, required 1 16 0", full, count, overflow);
    end
    send_frame(8'hEE, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: full=%b count=%0d overflow=%b, required 1 16 1", full, count, overflow);
    end
    send_frame(8'hEF, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      failures++;
      $display("FAIL ovf_set_wins: overflow=%b count=%0d, required 1 16", overflow, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp_b = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
        failures++;
        $display("FAIL ovf_drain%0d: rd_valid=%b rd_data=%h, required 1 %h", i, rd_valid, rd_data, exp_b);
      end
    end
    tick();
    checks++;
    if (empty !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drained: empty=%b rd_valid=%b overflow=%b, required 1 0 1", empty, rd_valid, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
    rx_busy = 1'b1;
    repeat (10) tick();
    rx_busy = 1'b0;
    rx_data = 8'h77;
    rd_en   = 1'b1;
    tick();
    rd_en   = 1'b0;
    exp_b = exp_q.pop_front();
    exp_q.push_back(8'h77);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_b || count !== 5'd16 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pushpop: rd_valid=%b rd_data=%h count=%0d overflow=%b, required 1 %h 16 0",
               rd_valid, rd_data, count, overflow, exp_b);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp_b = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
        failures++;
        $display("FAIL full_drain%0d: rd_valid=%b rd_data=%h, required 1 %h", i, rd_valid, rd_data, exp_b);
      end
    end
    checks++;
    if (rd_data !== 8'h77 || empty !== 1'b1) begin
      failures++;
      $display("FAIL full_last: rd_data=%h empty=%b, required 77 1", rd_data, empty);
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    rx_busy = 1'b1;
    tick();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_flush: count=%0d empty=%b overflow=%b rd_valid=%b, required 0 1 0 0",
               count, empty, overflow, rd_valid);
    end
    reset = 1'b0;
    repeat (4) tick();
    rx_busy = 1'b0;
    rx_data = 8'h99;
    tick();
    tick();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL rst_stale_frame: count=%0d empty=%b, required 0 1", count, empty);
    end
    send_frame(8'h42, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL rst_next_frame: count=%0d empty=%b, required 1 0", count, empty);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    exp_b = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
      failures++;
      $display("FAIL rst_read: rd_valid=%b rd_data=%h, required 1 %h", rd_valid, rd_data, exp_b);
    end
    tick();
  endtask

  task automatic test_empty_read();
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
        failures++;
        $display("FAIL empty_rd%0d: rd_valid=%b count=%0d empty=%b, required 0 0 1", i, rd_valid, count, empty);
      end
    end
    rd_en = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    exp_b = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_b || count !== 5'd0) begin
      failures++;
      $display("FAIL empty_then_push: rd_valid=%b rd_data=%h count=%0d, required 1 %h 0", rd_valid, rd_data, count, exp_b);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] v = 8'h80;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        send_frame(v, 1'b1, 1'b0);
        v = v + 8'd1;
      end
      checks++;
      if (count !== 5'd8 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL wrap_fill%0d: count=%0d overflow=%b, required 8 0", r, count, overflow);
      end
      for (int i = 0; i < 8; i++) begin
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        exp_b = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_b || overflow !== 1'b0) begin
          failures++;
          $display("FAIL wrap_read%0d_%0d: rd_valid=%b rd_data=%h overflow=%b, required 1 %h 0",
                   r, i, rd_valid, rd_data, overflow, exp_b);
        end
      end
      checks++;
      if (count !== 5'd0 || empty !== 1'b1) begin
        failures++;
        $display("FAIL wrap_drained%0d: count=%0d empty=%b, required 0 1", r, count, empty);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_reset_midframe();
    test_empty_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
